// File: rtl/multi_lane_datapath_reset.sv
// Datapath reset generator for a bonded multi-lane GT link: pulses rst_out when any enabled
// lane stays bad past a backoff-scaled timeout, and gives up after a bounded number of retries.
module multi_lane_datapath_reset #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned BACKOFF_SHIFT = 3,
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned MAX_RETRIES   = 8,
    parameter int unsigned STABLE_CYCLES = 256,
    localparam int unsigned RCW = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_LANES-1:0]     channel_good,
    input  logic [NUM_LANES-1:0]     lane_en,
    input  logic [COUNTER_WIDTH-1:0] timeout_cycles,
    input  logic                     retry_clr,
    output logic                     rst_out,
    output logic                     link_up,
    output logic                     failed,
    output logic [RCW-1:0]           retry_count,
    output logic [NUM_LANES-1:0]     bad_lanes
);

    localparam int unsigned WW   = COUNTER_WIDTH + BACKOFF_SHIFT;
    localparam int unsigned PCW  = (PULSE_CYCLES <= 1) ? 1 : $clog2(PULSE_CYCLES);
    localparam int unsigned SCW  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SHW  = (BACKOFF_SHIFT == 0) ? 1 : $clog2(BACKOFF_SHIFT + 1);
    localparam int unsigned RMAX = (MAX_RETRIES == 0) ? ((1 << RCW) - 1) : MAX_RETRIES;

    typedef enum logic [1:0] {
        ST_LINKED = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESET  = 2'd2,
        ST_FAILED = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [WW-1:0]       wait_cnt, wait_n;
    logic [PCW-1:0]      pulse_cnt, pulse_n;
    logic [SCW-1:0]      stable_cnt, stable_n;
    logic [RCW-1:0]      retry_n;

    logic                     all_good_c;
    logic [COUNTER_WIDTH-1:0] t_base_c;
    logic [SHW-1:0]           shift_c;
    logic [WW-1:0]            teff_c;
    logic [RCW-1:0]           retry_inc_c;

    // Effective timeout: max(T,1) scaled by the capped retry backoff.
    always_comb begin
        all_good_c  = &(channel_good | ~lane_en);
        t_base_c    = (timeout_cycles == '0) ? COUNTER_WIDTH'(1) : timeout_cycles;
        shift_c     = (32'(retry_count) >= BACKOFF_SHIFT) ? SHW'(BACKOFF_SHIFT) : SHW'(retry_count);
        teff_c      = WW'(t_base_c) << shift_c;
        retry_inc_c = (retry_count == RCW'(RMAX)) ? retry_count : retry_count + RCW'(1);
    end

    // Next-state and counter updates.
    always_comb begin
        state_n  = state;
        wait_n   = wait_cnt;
        pulse_n  = pulse_cnt;
        stable_n = stable_cnt;
        retry_n  = retry_count;
        case (state)
            ST_LINKED: begin
                if (!all_good_c) begin
                    state_n = ST_WAIT;
                    wait_n  = '0;
                end else if (stable_cnt != SCW'(STABLE_CYCLES)) begin
                    stable_n = stable_cnt + SCW'(1);
                    if (stable_n == SCW'(STABLE_CYCLES)) begin
                        retry_n = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (all_good_c) begin
                    state_n  = ST_LINKED;
                    stable_n = '0;
                end else if (wait_cnt >= teff_c - WW'(1)) begin
                    // >= so a timeout lowered mid-wait fires at once instead of wrapping
                    state_n = ST_RESET;
                    pulse_n = '0;
                end else begin
                    wait_n = wait_cnt + WW'(1);
                end
            end
            ST_RESET: begin
                if (pulse_cnt == PCW'(PULSE_CYCLES - 1)) begin
                    retry_n = retry_inc_c;
                    if (MAX_RETRIES != 0 && retry_inc_c == RCW'(MAX_RETRIES)) begin
                        state_n = ST_FAILED;
                    end else begin
                        state_n = ST_WAIT;
                        wait_n  = '0;
                    end
                end else begin
                    pulse_n = pulse_cnt + PCW'(1);
                end
            end
            ST_FAILED: begin
                if (all_good_c) begin
                    state_n  = ST_LINKED;
                    stable_n = '0;
                end else if (retry_clr) begin
                    state_n = ST_WAIT;
                    wait_n  = '0;
                    retry_n = '0;
                end
            end
            default: state_n = ST_WAIT;
        endcase
    end

    // State, counters and outputs; outputs decode the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_WAIT;
            wait_cnt    <= '0;
            pulse_cnt   <= '0;
            stable_cnt  <= '0;
            retry_count <= '0;
            rst_out     <= 1'b0;
            link_up     <= 1'b0;
            failed      <= 1'b0;
            bad_lanes   <= '0;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_n;
            pulse_cnt   <= pulse_n;
            stable_cnt  <= stable_n;
            retry_count <= retry_n;
            rst_out     <= (state_n == ST_RESET);
            link_up     <= (state_n == ST_LINKED);
            failed      <= (state_n == ST_FAILED);
            bad_lanes   <= lane_en & ~channel_good;
        end
    end

endmodule

// File: tb/tb_multi_lane_datapath_reset.sv
// Directed bench for multi_lane_datapath_reset: a default instance plus a MAX_RETRIES=3 instance
// share the same stimulus; rst_out rising cycles are logged against a cycle counter.
module tb_multi_lane_datapath_reset;

    localparam int unsigned NL = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] channel_good;
    logic [NL-1:0] lane_en;
    logic [CW-1:0] timeout_cycles;
    logic          retry_clr;

    logic          rst_out_a, link_up_a, failed_a;
    logic [3:0]    retry_a;
    logic [NL-1:0] bad_a;
    logic          rst_out_b, link_up_b, failed_b;
    logic [1:0]    retry_b;
    logic [NL-1:0] bad_b;

    always #5 clk = ~clk;

    multi_lane_datapath_reset u_dut_a (
        .clk(clk), .rst_n(rst_n), .channel_good(channel_good), .lane_en(lane_en),
        .timeout_cycles(timeout_cycles), .retry_clr(retry_clr),
        .rst_out(rst_out_a), .link_up(link_up_a), .failed(failed_a),
        .retry_count(retry_a), .bad_lanes(bad_a)
    );

    multi_lane_datapath_reset #(.MAX_RETRIES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .channel_good(channel_good), .lane_en(lane_en),
        .timeout_cycles(timeout_cycles), .retry_clr(retry_clr),
        .rst_out(rst_out_b), .link_up(link_up_b), .failed(failed_b),
        .retry_count(retry_b), .bad_lanes(bad_b)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   hi_a  = 0;
    int   rises_a[$];
    int   rises_b[$];
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    int   base;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nth(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // One clock; afterwards cyc names the cycle just entered.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_out_a && !prev_a) rises_a.push_back(cyc);
        if (rst_out_b && !prev_b) rises_b.push_back(cyc);
        if (rst_out_a) hi_a++;
        prev_a = rst_out_a;
        prev_b = rst_out_b;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        rises_a.delete();
        rises_b.delete();
        hi_a = 0;
    endtask

    initial begin
        int exp_rise[5];

        rst_n          = 1'b0;
        channel_good   = '1;
        lane_en        = '1;
        timeout_cycles = CW'(10);
        retry_clr      = 1'b0;
        run(3);
        check("rst_rst_out", 64'(rst_out_a), 64'd0);
        check("rst_link_up", 64'(link_up_a), 64'd0);
        check("rst_failed", 64'(failed_a), 64'd0);
        check("rst_retry", 64'(retry_a), 64'd0);
        channel_good = 4'b1011;
        run(1);
        check("rst_bad_lanes", 64'(bad_a), 64'd0);
        channel_good = '1;
        rst_n        = 1'b1;
        run(1);
        check("first_link_up", 64'(link_up_a), 64'd1);

        // Bad lane that is masked off must not disturb the link.
        clear_logs();
        lane_en      = 4'b1101;
        channel_good = 4'b1101;
        run(40);
        check("mask_rises", 64'(rises_a.size()), 64'd0);
        check("mask_link_up", 64'(link_up_a), 64'd1);
        check("mask_bad_lanes", 64'(bad_a), 64'd0);
        lane_en      = '1;
        channel_good = '1;
        run(2);

        // Recovery in the last WAIT cycle before the timeout.
        clear_logs();
        base         = cyc;
        channel_good = 4'b1011;
        run(10);
        check("w9_in_wait", 64'(link_up_a), 64'd0);
        channel_good = '1;
        run(1);
        check("w9_relinked", 64'(link_up_a), 64'd1);
        run(20);
        check("w9_no_pulse", 64'(rises_a.size()), 64'd0);
        check("w9_retry", 64'(retry_a), 64'd0);

        // Stuck lane: pulse timing, backoff, give-up and retry_clr.
        clear_logs();
        base         = cyc;
        channel_good = 4'b1011;
        run(1);
        check("stuck_bad_lanes", 64'(bad_a), 64'd4);
        run(14);
        check("p1_rise", 64'(nth(rises_a, 0)), 64'(base + 11));
        check("p1_width", 64'(hi_a), 64'd4);
        check("p1_retry", 64'(retry_a), 64'd1);
        run(245);
        exp_rise = '{11, 35, 79, 163, 247};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("backoff_rise%0d", i), 64'(nth(rises_a, i)), 64'(base + exp_rise[i]));
        end
        check("backoff_rise_count", 64'(rises_a.size()), 64'd5);
        check("backoff_high_total", 64'(hi_a), 64'd20);
        check("backoff_retry", 64'(retry_a), 64'd5);
        check("giveup_rises", 64'(rises_b.size()), 64'd3);
        check("giveup_failed", 64'(failed_b), 64'd1);
        check("giveup_retry", 64'(retry_b), 64'd3);
        check("giveup_rst_out", 64'(rst_out_b), 64'd0);
        retry_clr = 1'b1;
        run(1);
        retry_clr = 1'b0;
        check("clr_failed", 64'(failed_b), 64'd0);
        check("clr_retry", 64'(retry_b), 64'd0);
        check("clr_ignored", 64'(retry_a), 64'd5);
        run(14);
        check("clr_rise", 64'(nth(rises_b, 3)), 64'(base + 271));
        check("clr_retry_after", 64'(retry_b), 64'd1);

        // Recovery, then retry_count clears after exactly 256 linked cycles.
        channel_good = '1;
        run(1);
        check("rec_link_a", 64'(link_up_a), 64'd1);
        check("rec_link_b", 64'(link_up_b), 64'd1);
        run(255);
        check("stable255_a", 64'(retry_a), 64'd5);
        check("stable255_b", 64'(retry_b), 64'd1);
        run(1);
        check("stable256_a", 64'(retry_a), 64'd0);
        check("stable256_b", 64'(retry_b), 64'd0);

        // Zero timeout acts as one; reset asserted in the second cycle of a pulse.
        clear_logs();
        base           = cyc;
        timeout_cycles = '0;
        channel_good   = 4'b0111;
        run(9);
        check("t0_rise1", 64'(nth(rises_a, 0)), 64'(base + 2));
        check("t0_rise2", 64'(nth(rises_a, 1)), 64'(base + 8));
        check("t0_in_pulse", 64'(rst_out_a), 64'd1);
        check("t0_retry", 64'(retry_a), 64'd1);
        rst_n = 1'b0;
        run(1);
        check("mid_rst_out", 64'(rst_out_a), 64'd0);
        check("mid_link_up", 64'(link_up_a), 64'd0);
        check("mid_failed", 64'(failed_a), 64'd0);
        check("mid_retry", 64'(retry_a), 64'd0);
        check("mid_bad_lanes", 64'(bad_a), 64'd0);
        rst_n          = 1'b1;
        timeout_cycles = CW'(10);
        run(12);
        check("restart_rise", 64'(nth(rises_a, 2)), 64'(base + 20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
